// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the 8-bit RGB332 colours used by the pixel logic.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [7:0] rgb332_t;

    localparam rgb332_t BLACK       = 8'h00;
    localparam rgb332_t GREY        = 8'h92;
    localparam rgb332_t GREEN       = 8'h1C;
    localparam rgb332_t DARK_GREEN  = 8'h0C;
    localparam rgb332_t YELLOW      = 8'hFC;
    localparam rgb332_t ORANGE      = 8'hF0;
    localparam rgb332_t ZOMBIE_SKIN = 8'h95;

    // True when value lies in the half-open window [lo, lo+len).
    function automatic logic in_window(input logic [CNT_W-1:0] value,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (32'(value) >= lo) && (32'(value) < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on each step and flags the step that wraps to 0.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL = VGA_H_TOTAL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    logic [CNT_W-1:0] r_count;

    assign wrap  = step && (r_count == CNT_W'(TOTAL - 1));
    assign count = r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (wrap) begin
            r_count <= '0;
        end else if (step) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel divider, H/V counters, registered bright/sync and line/frame strobes.
// Optional VGA_FRAME_COUNT_EN adds a 16-bit wrapping frame counter output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned H_VISIBLE       = VGA_H_VISIBLE,
    parameter int unsigned H_FP            = VGA_H_FP,
    parameter int unsigned H_SYNC          = VGA_H_SYNC,
    parameter int unsigned H_BP            = VGA_H_BP,
    parameter int unsigned V_VISIBLE       = VGA_V_VISIBLE,
    parameter int unsigned V_FP            = VGA_V_FP,
    parameter int unsigned V_SYNC          = VGA_V_SYNC,
    parameter int unsigned V_BP            = VGA_V_BP,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             bright,
    output logic             hSync,
    output logic             vSync,
    output logic             pixel_en,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW;

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_pixel_en;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [CNT_W-1:0] w_h_count;
    logic [CNT_W-1:0] w_v_count;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_visible;
    logic             w_hs_active;
    logic             w_vs_active;
    logic             r_bright;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_line_start;
    logic             r_frame_start;

    assign w_pixel_en = enable && (r_div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (enable) begin
            r_div_cnt <= w_pixel_en ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (w_pixel_en),
        .count   (w_h_count),
        .wrap    (w_h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (w_h_wrap),
        .count   (w_v_count),
        .wrap    (w_v_wrap)
    );

    // Decode from the post-edge counter values so bright/syncs line up with hCount/vCount.
    assign w_h_next    = w_h_wrap ? '0 : (w_pixel_en ? w_h_count + CNT_W'(1) : w_h_count);
    assign w_v_next    = w_v_wrap ? '0 : (w_h_wrap   ? w_v_count + CNT_W'(1) : w_v_count);
    assign w_visible   = in_window(w_h_next, 0, H_VISIBLE) && in_window(w_v_next, 0, V_VISIBLE);
    assign w_hs_active = in_window(w_h_next, H_VISIBLE + H_FP, H_SYNC);
    assign w_vs_active = in_window(w_v_next, V_VISIBLE + V_FP, V_SYNC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bright      <= 1'b0;
            r_hsync       <= SYNC_IDLE;
            r_vsync       <= SYNC_IDLE;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_bright      <= enable && w_visible;
            r_hsync       <= (enable && w_hs_active) ^ SYNC_ACTIVE_LOW;
            r_vsync       <= (enable && w_vs_active) ^ SYNC_ACTIVE_LOW;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
        end else if (w_v_wrap) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign hCount      = w_h_count;
    assign vCount      = w_v_count;
    assign bright      = r_bright;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign pixel_en    = w_pixel_en;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 24x13 raster: one active-low instance
// (CLK_DIV=4) and one active-high instance (CLK_DIV=2) sharing clock, reset and enable.
module tb_vga_timing_gen;

    localparam int unsigned HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VV = 8,  VF = 1, VS = 2, VB = 2;
    localparam int unsigned HT = 24, VT = 13;
    localparam int unsigned LINE1  = 4 * HT;        // 96 clocks per line, CLK_DIV=4
    localparam int unsigned FRAME1 = LINE1 * VT;    // 1248
    localparam int unsigned LINE2  = 2 * HT;        // 48
    localparam int unsigned FRAME2 = LINE2 * VT;    // 624
    localparam int unsigned HOLD_A = 203;           // visible area, on a would-be pixel step
    localparam int unsigned HOLD_B = 2 * FRAME1 + FRAME1 - 1;  // last pixel of frame, on the wrap edge
    localparam int unsigned HOLD_LEN = 50;
    localparam int          RUN = 4161;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [9:0] h1, v1, h2, v2;
    logic       bright1, hsync1, vsync1, pix1, line1, frame1;
    logic       bright2, hsync2, vsync2, pix2, line2, frame2;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fcount1, fcount2;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          cur_cycle = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(4), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .hCount(h1), .vCount(v1), .bright(bright1), .hSync(hsync1), .vSync(vsync1),
        .pixel_en(pix1), .line_start(line1), .frame_start(frame1)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(fcount1)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE_LOW(1'b0)
    ) u_dut_pos (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .hCount(h2), .vCount(v2), .bright(bright2), .hSync(hsync2), .vSync(vsync2),
        .pixel_en(pix2), .line_start(line2), .frame_start(frame2)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(fcount2)
`endif
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cur_cycle, got, exp);
        end
    endtask

    function automatic int unsigned h_of(input int unsigned e, input int unsigned cd);
        return (e / cd) % HT;
    endfunction

    function automatic int unsigned v_of(input int unsigned e, input int unsigned cd);
        return (e / cd / HT) % VT;
    endfunction

    // e = enabled clock edges since reset release; en = enable applied on the latest edge.
    task automatic check_cycle(input bit en, input int unsigned e);
        int unsigned a_h, a_v, b_h, b_v;
        bit a_vis, b_vis, a_hs, a_vs, b_hs, b_vs;
        a_h = h_of(e, 4);  a_v = v_of(e, 4);
        b_h = h_of(e, 2);  b_v = v_of(e, 2);
        a_vis = en && (a_h < HV) && (a_v < VV);
        b_vis = en && (b_h < HV) && (b_v < VV);
        a_hs  = en && (a_h >= HV + HF) && (a_h < HV + HF + HS);
        a_vs  = en && (a_v >= VV + VF) && (a_v < VV + VF + VS);
        b_hs  = en && (b_h >= HV + HF) && (b_h < HV + HF + HS);
        b_vs  = en && (b_v >= VV + VF) && (b_v < VV + VF + VS);
        check("h1",      32'(h1),      a_h);
        check("v1",      32'(v1),      a_v);
        check("bright1", 32'(bright1), 32'(a_vis));
        check("hsync1",  32'(hsync1),  32'(!a_hs));
        check("vsync1",  32'(vsync1),  32'(!a_vs));
        check("pix1",    32'(pix1),    32'(en && (e % 4 == 3)));
        check("line1",   32'(line1),   32'(en && e != 0 && (e % LINE1 == 0)));
        check("frame1",  32'(frame1),  32'(en && e != 0 && (e % FRAME1 == 0)));
        check("h2",      32'(h2),      b_h);
        check("v2",      32'(v2),      b_v);
        check("bright2", 32'(bright2), 32'(b_vis));
        check("hsync2",  32'(hsync2),  32'(b_hs));
        check("vsync2",  32'(vsync2),  32'(b_vs));
        check("pix2",    32'(pix2),    32'(en && (e % 2 == 1)));
        check("line2",   32'(line2),   32'(en && e != 0 && (e % LINE2 == 0)));
        check("frame2",  32'(frame2),  32'(en && e != 0 && (e % FRAME2 == 0)));
    endtask

    typedef struct {
        int unsigned e;
        int unsigned h;
        int unsigned v;
        bit          bright;
        bit          hs;
        bit          vs;
    } vec_t;

    // Hand-computed boundary points for the CLK_DIV=4 instance (active-low syncs).
    vec_t vecs[11] = '{
        '{e:   63, h: 15, v:  0, bright: 1'b1, hs: 1'b1, vs: 1'b1},
        '{e:   64, h: 16, v:  0, bright: 1'b0, hs: 1'b1, vs: 1'b1},
        '{e:   71, h: 17, v:  0, bright: 1'b0, hs: 1'b1, vs: 1'b1},
        '{e:   72, h: 18, v:  0, bright: 1'b0, hs: 1'b0, vs: 1'b1},
        '{e:   83, h: 20, v:  0, bright: 1'b0, hs: 1'b0, vs: 1'b1},
        '{e:   84, h: 21, v:  0, bright: 1'b0, hs: 1'b1, vs: 1'b1},
        '{e:  732, h: 15, v:  7, bright: 1'b1, hs: 1'b1, vs: 1'b1},
        '{e:  768, h:  0, v:  8, bright: 1'b0, hs: 1'b1, vs: 1'b1},
        '{e:  864, h:  0, v:  9, bright: 1'b0, hs: 1'b1, vs: 1'b0},
        '{e: 1055, h: 23, v: 10, bright: 1'b0, hs: 1'b1, vs: 1'b0},
        '{e: 1056, h:  0, v: 11, bright: 1'b0, hs: 1'b1, vs: 1'b1}
    };

    initial begin
        int unsigned e = 0;
        int unsigned hold = 0;
        bit done_a = 1'b0, done_b = 1'b0, en;
        int fr_k[3] = '{0, 0, 0};
        int fr_n = 0;
        int unsigned lines_in_frame = 0;

        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_h1",      32'(h1),      0);
        check("rst_v1",      32'(v1),      0);
        check("rst_bright1", 32'(bright1), 0);
        check("rst_hsync1",  32'(hsync1),  1);
        check("rst_vsync1",  32'(vsync1),  1);
        check("rst_hsync2",  32'(hsync2),  0);
        check("rst_vsync2",  32'(vsync2),  0);
        check("rst_strobes", 32'({pix1, line1, frame1}), 0);

        reset_n = 1'b1;
        for (int k = 1; k <= RUN; k++) begin
            cur_cycle = k;
            if (hold == 0 && e == HOLD_A && !done_a) begin hold = HOLD_LEN; done_a = 1'b1; end
            if (hold == 0 && e == HOLD_B && !done_b) begin hold = HOLD_LEN; done_b = 1'b1; end
            en = (hold == 0);
            if (hold != 0) hold--;
            enable = en;
            @(posedge clk);
            if (en) e++;
            @(negedge clk);
            check_cycle(en, e);
            if (en) begin
                for (int i = 0; i < 11; i++) begin
                    if (vecs[i].e == e) begin
                        check("vec_h",      32'(h1),      vecs[i].h);
                        check("vec_v",      32'(v1),      vecs[i].v);
                        check("vec_bright", 32'(bright1), 32'(vecs[i].bright));
                        check("vec_hsync",  32'(hsync1),  32'(vecs[i].hs));
                        check("vec_vsync",  32'(vsync1),  32'(vecs[i].vs));
                    end
                end
            end
            if (fr_n == 1 && line1) lines_in_frame++;
            if (frame1 && fr_n < 3) begin
                fr_k[fr_n] = k;
                fr_n++;
            end
        end

        check("frame_count_seen", 32'(fr_n), 3);
        check("frame_period",     32'(fr_k[1] - fr_k[0]), FRAME1);
        check("frame_period_held", 32'(fr_k[2] - fr_k[1]), FRAME1 + HOLD_LEN);
        check("lines_per_frame",  lines_in_frame, VT);
        check("pre_rst_h1", 32'(h1), 7);
        check("pre_rst_v1", 32'(v1), 3);
`ifdef VGA_FRAME_COUNT_EN
        check("fcount1", 32'(fcount1), 3);
        check("fcount2", 32'(fcount2), 6);
`endif

        // Asynchronous reset between edges, mid-line in the visible area.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_h1",      32'(h1),      0);
        check("arst_v1",      32'(v1),      0);
        check("arst_bright1", 32'(bright1), 0);
        check("arst_hsync1",  32'(hsync1),  1);
        check("arst_vsync1",  32'(vsync1),  1);
        check("arst_hsync2",  32'(hsync2),  0);
        check("arst_pix1",    32'(pix1),    0);
`ifdef VGA_FRAME_COUNT_EN
        check("arst_fcount1", 32'(fcount1), 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        @(posedge clk); #1;
        check("rel_bright1", 32'(bright1), 1);
        check("rel_h1",      32'(h1),      0);
        check("rel_pix1",    32'(pix1),    0);
        check("rel_pix2",    32'(pix2),    1);
        repeat (2) @(posedge clk); #1;
        check("rel_pix1_e3", 32'(pix1), 1);
        check("rel_h1_e3",   32'(h1),   0);
        @(posedge clk); #1;
        check("rel_h1_e4",   32'(h1),   1);
        check("rel_h2_e4",   32'(h2),   2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
